// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per clock, LSB digit first.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             carry, c_nx, last;
    logic [DIGIT-1:0] dsum;

    assign last = cnt == CW'(N - 1);
    assign busy = state == RUN;
    assign done = state == DONE;

    always_comb begin
        dsum = '0;
        c_nx = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_r[i] ^ b_r[i] ^ c_nx;
            c_nx    = (a_r[i] & b_r[i]) | (a_r[i] & c_nx) | (b_r[i] & c_nx);
        end
    end

    // each new digit enters at the top, so after N digits acc holds the full result
    assign acc_nx = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_comb begin
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_r   <= a;
                b_r   <= b;
                carry <= c_in;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_r   <= a_r >> DIGIT;
                b_r   <= b_r >> DIGIT;
                acc   <= acc_nx;
                carry <= c_nx;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum   <= acc_nx;
                    c_out <= c_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: six serial_adder configurations driven in lockstep and checked
// against an integer-sum model plus hand-computed vectors.
module tb_serial_adder;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  s0, s2, s3;
    logic [0:0]  s1;
    logic [15:0] s4;
    logic [31:0] s5;
    logic [5:0]  co, bz, dn;
    logic [31:0] sm [6];
    logic [32:0] prev [6];
    int          tests = 0, fails = 0;

    localparam int WD [6] = '{8, 1, 8, 8, 16, 32};
    localparam int NN [6] = '{8, 1, 2, 4, 4, 4};

    always #5 clk = ~clk;

    assign sm[0] = 32'(s0);
    assign sm[1] = 32'(s1);
    assign sm[2] = 32'(s2);
    assign sm[3] = 32'(s3);
    assign sm[4] = 32'(s4);
    assign sm[5] = s5;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
        .c_in(c_in), .busy(bz[0]), .done(dn[0]), .sum(s0), .c_out(co[0]));
    serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[0:0]), .b(b[0:0]),
        .c_in(c_in), .busy(bz[1]), .done(dn[1]), .sum(s1), .c_out(co[1]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
        .c_in(c_in), .busy(bz[2]), .done(dn[2]), .sum(s2), .c_out(co[2]));
    serial_adder #(.WIDTH(8), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
        .c_in(c_in), .busy(bz[3]), .done(dn[3]), .sum(s3), .c_out(co[3]));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .a(a[15:0]), .b(b[15:0]),
        .c_in(c_in), .busy(bz[4]), .done(dn[4]), .sum(s4), .c_out(co[4]));
    serial_adder #(.WIDTH(32), .DIGIT(8)) u5 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .c_in(c_in), .busy(bz[5]), .done(dn[5]), .sum(s5), .c_out(co[5]));

    function automatic logic [32:0] model(int i, logic [31:0] x, logic [31:0] y, logic c);
        logic [63:0] m, e;
        m = (64'd1 << WD[i]) - 64'd1;
        e = (64'(x) & m) + (64'(y) & m) + 64'(c);
        return 33'(e);
    endfunction

    function automatic logic [32:0] act(int i);
        return 33'(sm[i]) | (33'(co[i]) << WD[i]);
    endfunction

    task automatic chk(string n, int i, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", n, i, got, exp);
        end
    endtask

    // one operation on all DUTs; poke pulses start mid-operation with fresh operands
    task automatic op(logic [31:0] x, logic [31:0] y, logic c, bit poke);
        int          ndone [6], lat [6], nbusy [6], both [6];
        logic [32:0] exp [6];
        for (int i = 0; i < 6; i++) begin
            exp[i] = model(i, x, y, c);
            ndone[i] = 0; lat[i] = -1; nbusy[i] = 0; both[i] = 0;
        end
        @(negedge clk);
        a = x; b = y; c_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; c_in = 1'($urandom);
        for (int i = 0; i < 6; i++) chk("hold", i, 64'(act(i)), 64'(prev[i]));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (bz[i]) nbusy[i]++;
                if (dn[i]) begin
                    ndone[i]++;
                    if (lat[i] < 0) lat[i] = k + 1;
                end
                if (bz[i] && dn[i]) both[i]++;
            end
            if (poke && k == 1) begin start = 1'b1; a = 32'd1; b = 32'd1; end
            if (poke && k == 2) start = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            chk("latency", i, 64'(lat[i]), 64'(NN[i] + 1));
            chk("done_pulses", i, 64'(ndone[i]), 64'd1);
            chk("busy_cycles", i, 64'(nbusy[i]), 64'(NN[i]));
            chk("busy_and_done", i, 64'(both[i]), 64'd0);
            chk("result", i, 64'(act(i)), 64'(exp[i]));
            prev[i] = exp[i];
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        bit         poke;
        logic [8:0] e8;
        logic [1:0] e1;
    } vec_t;

    vec_t v [11];

    initial begin
        int t0, gap, nd;
        v[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 2'd0};
        v[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 9'h001, 2'd1};
        v[2]  = '{8'h00, 8'h01, 1'b0, 1'b0, 9'h001, 2'd1};
        v[3]  = '{8'h00, 8'h01, 1'b1, 1'b0, 9'h002, 2'd2};
        v[4]  = '{8'h01, 8'h00, 1'b0, 1'b0, 9'h001, 2'd1};
        v[5]  = '{8'h01, 8'h00, 1'b1, 1'b0, 9'h002, 2'd2};
        v[6]  = '{8'h01, 8'h01, 1'b0, 1'b0, 9'h002, 2'd2};
        v[7]  = '{8'h01, 8'h01, 1'b1, 1'b0, 9'h003, 2'd3};
        v[8]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 2'd2};
        v[9]  = '{8'h5A, 8'hA5, 1'b1, 1'b0, 9'h100, 2'd2};
        v[10] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF, 2'd3};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("reset_busy", i, 64'(bz[i]), 64'd0);
            chk("reset_done", i, 64'(dn[i]), 64'd0);
            chk("reset_result", i, 64'(act(i)), 64'd0);
            prev[i] = '0;
        end
        rst_n = 1'b1;

        for (int t = 0; t < 11; t++) begin
            op(32'(v[t].a), 32'(v[t].b), v[t].c, v[t].poke);
            chk("vec_w8d1", 0, 64'(act(0)), 64'(v[t].e8));
            chk("vec_w1d1", 1, 64'(act(1)), 64'(v[t].e1));
            chk("vec_w8d4", 2, 64'(act(2)), 64'(v[t].e8));
        end

        // abort after three RUN edges
        op(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("abort_busy", i, 64'(bz[i]), 64'd0);
            chk("abort_done", i, 64'(dn[i]), 64'd0);
            chk("abort_result", i, 64'(act(i)), 64'd0);
            prev[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn != '0) nd++;
        end
        chk("abort_no_done", 0, 64'(nd), 64'd0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

        // start held high: results every N+2 cycles
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h8765_4321; c_in = 1'b0; start = 1'b1;
        t0 = -1; gap = -1;
        for (int k = 0; k < 40 && gap < 0; k++) begin
            @(negedge clk);
            if (dn[0]) begin
                if (t0 < 0) t0 = k;
                else gap = k - t0;
            end
        end
        chk("back_to_back_gap", 0, 64'(gap), 64'd10);
        start = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            prev[i] = model(i, 32'h1234_5678, 32'h8765_4321, 1'b0);
            chk("back_to_back_result", i, 64'(act(i)), 64'(prev[i]));
        end

        for (int r = 0; r < 1000; r++) op($urandom, $urandom, 1'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 1.
REQ-002 Parameter DIGIT, default 1, bits added per clock cycle; SHALL divide WIDTH exactly; N = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on rising edge.
REQ-006 a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-007 b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-008 c_in  input  1  carry-in; sampled only on an accepted start.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  single-cycle pulse marking a completed result.
REQ-011 sum  output  WIDTH  registered result (a + b + c_in) mod 2^WIDTH.
REQ-012 c_out  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL be accepted, latching a, b and c_in and clearing the digit counter, and the FSM SHALL move to RUN.
REQ-015 RUN: each edge SHALL add the next DIGIT bits, LSB digit first, plus the carry register, then store the digit result and update the carry.
REQ-016 RUN SHALL last exactly N edges; on the N-th edge, sum and c_out SHALL be loaded and the FSM SHALL move to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge E0 SHALL give done=1 in the cycle after edge E0+N, with no dependence on operand values.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never both be 1.
REQ-020 start SHALL be ignored in RUN and DONE; operand inputs SHALL have no effect except on an accepted start.
REQ-021 sum and c_out SHALL change only on the N-th RUN edge and SHALL hold their value until the next completion or reset.
REQ-022 Per-digit arithmetic SHALL equal a DIGIT-wide ripple of full adders (sum bit = a^b^c, carry = ab|ac|bc); the carry SHALL chain across digits.
REQ-023 The result SHALL equal the full (WIDTH+1)-bit sum {c_out,sum} = a + b + c_in, with wrap-around modulo 2^WIDTH.
REQ-024 Back-to-back operation: start held high SHALL be accepted again in IDLE, giving one result every N+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, c_out=0 and clear the internal carry, counter and operand registers, with no clock required.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and sum/c_out SHALL read 0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted at the next rising edge at which start=1.

Verification
REQ-028 WIDTH=1, DIGIT=1, all 8 combinations of a, b and c_in -> {c_out,sum} matches the full-adder truth table, with done 2 cycles after start.
REQ-029 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, done exactly 9 cycles after the start edge; busy high for exactly 8 cycles.
REQ-030 WIDTH=8, DIGIT=4: a=0x5A, b=0xA5, c_in=1 -> sum=0x00, c_out=1, done 3 cycles after start.
REQ-031 WIDTH=8, DIGIT=1: a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1; then start pulsed mid-RUN with a=0x01, b=0x01 -> ignored, result unchanged, only one done pulse.
REQ-032 Reset asserted after 3 RUN cycles -> busy, done, sum and c_out go to 0 asynchronously; no done pulse follows; a new start then completes normally.
REQ-033 Random regression of at least 1000 operands for (WIDTH,DIGIT) in {(8,1),(8,2),(16,4),(32,8)} -> {c_out,sum} == a+b+c_in, with latency N+1 every time.
